timer_dev: RTL and testbench

- Memory-mapped interval timer that sits behind the system bridge as a bus responder.
- It answers the CPU's PrAddr/PrWD/PrWE/PrRD accesses, which the bridge decodes and forwards as Addr/WE/DIn/DOut.
- Its IRQ output drives one bit of the CPU's HWInt[7:2] vector.
- It provides a one-shot mode and an auto-reload mode, with a maskable interrupt.

---
 rtl/timer_dev.sv | 124 ++++++++++++
 tb/tb_timer_dev.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// Memory-mapped interval timer behind the system bridge: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload countdown, and a maskable level interrupt for HWInt.
module timer_dev (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] DIn,
   output logic [31:0] DOut,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic        enable, enable_nxt;
   logic [1:0]  mode, mode_nxt;
   logic        im, im_nxt;
   logic [31:0] preset, preset_nxt;
   logic [31:0] count, count_nxt;
   logic        irq_flag, irq_flag_nxt;
   logic        flag_set, flag_clr_fsm;
   logic        wr_ctrl, wr_preset;

   // Bus: no handshake. A write commits at the rising edge where WE=1; a read is a pure
   // combinational decode of Addr with no side effects.
   assign wr_ctrl   = WE && (Addr == 2'd0);
   assign wr_preset = WE && (Addr == 2'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         enable   <= 1'b0;
         mode     <= 2'd0;
         im       <= 1'b0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         state    <= state_nxt;
         enable   <= enable_nxt;
         mode     <= mode_nxt;
         im       <= im_nxt;
         preset   <= preset_nxt;
         count    <= count_nxt;
         irq_flag <= irq_flag_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      enable_nxt   = enable;
      mode_nxt     = mode;
      im_nxt       = im;
      preset_nxt   = preset;
      count_nxt    = count;
      flag_set     = 1'b0;
      flag_clr_fsm = 1'b0;

      case (state)
         IDLE: begin
            if (enable) state_nxt = LOAD;
         end
         LOAD: begin
            count_nxt = preset;
            state_nxt = CNT;
         end
         CNT: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (count <= 32'd1) begin
               count_nxt = 32'd0;
               flag_set  = 1'b1;
               state_nxt = INT;
            end else begin
               count_nxt = count - 32'd1;
            end
         end
         INT: begin
            if (mode == 2'd1) begin
               flag_clr_fsm = 1'b1;
               state_nxt    = LOAD;
            end else begin
               enable_nxt = 1'b0;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Bus writes are applied after the FSM so a CTRL write overrides the one-shot Enable clear.
      if (wr_ctrl) begin
         enable_nxt = DIn[0];
         mode_nxt   = DIn[2:1];
         im_nxt     = DIn[3];
      end
      if (wr_preset) preset_nxt = DIn;

      if (flag_set)
         irq_flag_nxt = 1'b1;
      else if (wr_ctrl || wr_preset || flag_clr_fsm)
         irq_flag_nxt = 1'b0;
      else
         irq_flag_nxt = irq_flag;
   end

   always_comb begin
      DOut = 32'd0;
      case (Addr)
         2'd0:    DOut = {28'd0, im, mode, enable};
         2'd1:    DOut = preset;
         2'd2:    DOut = count;
         default: DOut = 32'd0;
      endcase
   end

   assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_timer_dev.sv
// Directed and randomized checks of timer_dev against cycle timing derived from
// closed-form countdown/reload arithmetic.
module tb_timer_dev;

   logic        clk;
   logic        reset;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] DIn;
   logic [31:0] DOut;
   logic        IRQ;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   int unsigned rn, rm, rim, per, len;
   bit          reload;

   timer_dev dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .DIn   (DIn),
      .DOut  (DOut),
      .IRQ   (IRQ)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      WE    = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   // Driver tasks
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = a;
      DIn  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE  = 1'b0;
      DIn = 32'd0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
      Addr = a;
      #1;
      check(tag, DOut, exp);
   endtask

   task automatic check_irq(input string tag, input logic exp);
      check(tag, {31'd0, IRQ}, {31'd0, exp});
   endtask

   // Reference timing: with PRESET=n the cycle period is max(n,1)+2 edges after the enabling
   // write; within a period, offsets 0 and 1 show COUNT=0, offsets >=2 count down from n.
   function automatic logic [31:0] model_count(input int unsigned n, input int unsigned p,
                                               input bit rl, input int unsigned k);
      int unsigned j;
      if (!rl && k >= p) return 32'd0;
      j = k % p;
      if (j < 2) return 32'd0;
      return 32'(n - (j - 2));
   endfunction

   function automatic logic model_irq(input bit imb, input int unsigned p,
                                      input bit rl, input int unsigned k);
      if (rl) return imb && (k % p == 0);
      return imb && (k >= p);
   endfunction

   function automatic logic [31:0] model_ctrl(input bit imb, input int unsigned m,
                                              input int unsigned p, input bit rl,
                                              input int unsigned k);
      bit en;
      en = rl || (k < p + 1);
      return {28'd0, imb, 2'(m), en};
   endfunction

   initial begin
      reset = 1'b1;
      Addr  = 2'd0;
      WE    = 1'b0;
      DIn   = 32'd0;

      // Reset state
      do_reset();
      check_rd("rst_ctrl", 2'd0, 32'd0);
      check_rd("rst_preset", 2'd1, 32'd0);
      check_rd("rst_count", 2'd2, 32'd0);
      check_rd("rst_addr3", 2'd3, 32'd0);
      check_irq("rst_irq", 1'b0);

      // One-shot, PRESET=3, IM=1
      do_reset();
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      tick(2);
      check_rd("os_count_e2", 2'd2, 32'd3);
      tick(1);
      check_rd("os_count_e3", 2'd2, 32'd2);
      tick(1);
      check_rd("os_count_e4", 2'd2, 32'd1);
      check_irq("os_irq_e4", 1'b0);
      tick(1);
      check_irq("os_irq_e5", 1'b1);
      tick(1);
      check_rd("os_ctrl_e6", 2'd0, 32'h8);
      check_irq("os_irq_e6", 1'b1);
      tick(3);
      check_irq("os_irq_hold", 1'b1);
      check_rd("os_count_hold", 2'd2, 32'd0);
      wr(2'd0, 32'h8);
      check_irq("os_irq_clr", 1'b0);

      // Auto-reload, PRESET=2: pulse every 4 cycles
      do_reset();
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 14; k++) begin
         tick(1);
         check_irq($sformatf("ar_irq_k%0d", k), (k % 4) == 0);
         check_rd($sformatf("ar_ctrl_k%0d", k), 2'd0, 32'hB);
      end

      // Disable mid-count freezes COUNT, ignored writes, reload, reset mid-count
      do_reset();
      wr(2'd1, 32'd7);
      wr(2'd0, 32'h9);
      tick(4);
      check_rd("dis_count5", 2'd2, 32'd5);
      wr(2'd0, 32'h8);
      check_rd("dis_count4", 2'd2, 32'd4);
      tick(3);
      check_rd("dis_frozen", 2'd2, 32'd4);
      check_irq("dis_irq", 1'b0);
      wr(2'd2, 32'hFFFF_FFFF);
      wr(2'd3, 32'h0000_1234);
      check_rd("ro_count", 2'd2, 32'd4);
      check_rd("ro_addr3", 2'd3, 32'd0);
      check_rd("ro_preset", 2'd1, 32'd7);
      check_rd("ro_ctrl", 2'd0, 32'h8);
      wr(2'd0, 32'h9);
      tick(2);
      check_rd("reload_count", 2'd2, 32'd7);
      tick(1);
      check_rd("reload_dec", 2'd2, 32'd6);
      reset = 1'b1;
      Addr  = 2'd1;
      DIn   = 32'd5;
      WE    = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      WE    = 1'b0;
      check_rd("midrst_ctrl", 2'd0, 32'd0);
      check_rd("midrst_preset", 2'd1, 32'd0);
      check_rd("midrst_count", 2'd2, 32'd0);
      check_rd("midrst_addr3", 2'd3, 32'd0);
      check_irq("midrst_irq", 1'b0);
      tick(3);
      check_rd("midrst_idle_count", 2'd2, 32'd0);

      // Mask: flag set with IM=0, then cleared by the IM write
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h1);
      tick(3);
      check_irq("mask_irq_e3", 1'b0);
      tick(1);
      check_rd("mask_ctrl_e4", 2'd0, 32'h0);
      wr(2'd0, 32'h8);
      check_irq("mask_clr_irq", 1'b0);
      tick(2);
      check_irq("mask_clr_hold", 1'b0);

      // Mask: IM write on the same edge as the flag set, set wins
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h1);
      tick(2);
      wr(2'd0, 32'h8);
      check_irq("setwins_irq", 1'b1);
      tick(2);
      check_irq("setwins_hold", 1'b1);
      check_rd("setwins_ctrl", 2'd0, 32'h8);

      // CTRL write on the edge where one-shot INT clears Enable: write wins
      do_reset();
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h9);
      tick(3);
      check_irq("cpuwins_irq_e3", 1'b1);
      wr(2'd0, 32'h9);
      check_rd("cpuwins_ctrl", 2'd0, 32'h9);
      check_irq("cpuwins_irq_clr", 1'b0);
      tick(2);
      check_irq("cpuwins_irq_e6", 1'b0);
      tick(1);
      check_irq("cpuwins_irq_e7", 1'b1);

      // Randomized trials against the arithmetic timing model
      for (int t = 0; t < 10; t++) begin
         rn     = $urandom_range(0, 6);
         rm     = $urandom_range(0, 3);
         rim    = $urandom_range(0, 1);
         reload = (rm == 1);
         per    = ((rn == 0) ? 1 : rn) + 2;
         len    = 3 * per + 2;
         exp_q.delete();
         for (int k = 1; k <= len; k++) begin
            exp_q.push_back(model_count(rn, per, reload, k));
            exp_q.push_back({31'd0, model_irq(rim[0], per, reload, k)});
            exp_q.push_back(model_ctrl(rim[0], rm, per, reload, k));
         end
         do_reset();
         wr(2'd1, 32'(rn));
         wr(2'd0, {28'd0, rim[0], 2'(rm), 1'b1});
         for (int k = 1; k <= len; k++) begin
            tick(1);
            exp_v = exp_q.pop_front();
            check_rd($sformatf("rnd%0d_n%0d_m%0d_count_k%0d", t, rn, rm, k), 2'd2, exp_v);
            exp_v = exp_q.pop_front();
            check($sformatf("rnd%0d_n%0d_m%0d_irq_k%0d", t, rn, rm, k), {31'd0, IRQ}, exp_v);
            exp_v = exp_q.pop_front();
            check_rd($sformatf("rnd%0d_n%0d_m%0d_ctrl_k%0d", t, rn, rm, k), 2'd0, exp_v);
         end
      end

      // Final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
